// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, add/subtract mode constants and
// the WIDTH/DIGIT legality check used by the digit-serial arithmetic path.
`ifndef ALU_PKG_SV
`define ALU_PKG_SV

// Elaboration-time rejection of unusable WIDTH/DIGIT combinations.
`define ALU_PARAM_CHECK(W, D) \
  if ((W) < 1 || (D) < 1 || (D) > (W) || ((W) % (D)) != 0) begin : g_param_check \
    $error("illegal WIDTH/DIGIT combination"); \
  end

package alu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

`endif

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple-carry chain of full-adder cells.
// Ports:
//   a, b  : digit operands
//   cin   : carry into bit 0
//   s     : digit sum
//   cout  : carry out of the top bit
//   ctop  : carry into the top bit (overflow detection on the MSB digit)
module adder_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             ctop
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign ctop = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock. A run takes
// WIDTH/DIGIT cycles; results are only published on the edge that enters FIN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, accepted when ready=1
//   a, b, cin, sub      : operands, carry-in, mode (0 add, 1 subtract); sampled on accept
//   ready, busy, done   : handshake; done is a one-cycle pulse in FIN
//   sum, cout, ovf      : held result, carry-out (1 = no borrow on subtract), signed overflow
module digit_serial_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  `ALU_PARAM_CHECK(WIDTH, DIGIT)

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, psum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0] sl_sum;
  logic             sl_cout, sl_ctop;
  logic             accept, last;
  logic [WIDTH-1:0] psum_nxt;

  adder_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (sl_sum),
    .cout(sl_cout),
    .ctop(sl_ctop)
  );

  // New digit enters at the top; after N digits digit 0 sits at the LSB.
  assign psum_nxt = (psum_q >> DIGIT) | (WIDTH'(sl_sum) << (WIDTH - DIGIT));
  assign last     = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StFin;
      end
      StFin: begin
        ready   = 1'b1;
        done    = 1'b1;
        accept  = start;
        state_d = start ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtract is A + ~B + 1; the +1 rides in through the carry register.
        a_q     <= a;
        b_q     <= b ^ {WIDTH{sub == MODE_SUB}};
        carry_q <= cin ^ (sub != MODE_ADD);
        cnt_q   <= '0;
      end else if (state_q == StRun) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= sl_cout;
        psum_q  <= psum_nxt;
        cnt_q   <= cnt_q + CW'(1);
        if (last) begin
          sum_q  <= psum_nxt;
          cout_q <= sl_cout;
          ovf_q  <= sl_cout ^ sl_ctop;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes `DIGIT` bits per clock through a `DIGIT`-wide full-adder chain. It produces a `WIDTH`-bit sum, carry-out and signed overflow after `WIDTH/DIGIT` cycles. It is the sequential successor of the single-bit full adder and sits in the ALU as the area-optimised arithmetic path, trading latency for a narrow carry chain. It uses a start/ready/done handshake.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width. Must be ≥ 1.
- `DIGIT`, 4: bits processed per cycle. Must satisfy `WIDTH % DIGIT == 0`. `DIGIT == WIDTH` is legal and gives a single-cycle run.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `START`  in  1  request; accepted only when `READY=1`.
- `A`  in  WIDTH  operand A; sampled on accept.
- `B`  in  WIDTH  operand B; sampled on accept.
- `CIN`  in  1  carry-in; sampled on accept.
- `SUB`  in  1  0 = add, 1 = subtract; sampled on accept.
- `READY`  out  1  block can accept `START`.
- `BUSY`  out  1  run in progress.
- `DONE`  out  1  one-cycle pulse when the result registers update.
- `SUM`  out  WIDTH  result; held until the next `DONE`.
- `COUT`  out  1  carry-out of the MSB. On subtract, 1 means no borrow.
- `OVF`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
FSM states: IDLE, RUN, FIN.
- **IDLE:** `READY=1`. `START=1` latches `A`, `B ^ {WIDTH{SUB}}` and carry `CIN ^ SUB`, clears the digit counter, then → RUN.
- **RUN:** `BUSY=1`, `READY=0`. Each cycle adds digit `k` (bits `k*DIGIT +: DIGIT`) with the carry register and shifts the result into the partial-sum register. The counter increments.
  - The carry into the MSB is captured on the last digit.
  - After the digit with index `N-1` (`N = WIDTH/DIGIT`): `SUM`, `COUT` and `OVF` load from the internal registers, then → FIN.
- **FIN:** `DONE=1`, `READY=1`. `START=1` accepts a new operation (back-to-back) → RUN. Otherwise → IDLE.
- Subtract: `SUB=1, CIN=0` gives `A-B`. `SUB=1, CIN=1` gives `A-B-1`. Add with `CIN=1` gives `A+B+1`.
- `START` while `BUSY` is ignored. No queuing, no error flag.
- Operand changes after accept have no effect on the running operation.
- `SUM`, `COUT` and `OVF` never show partial values. They change only on the edge that enters FIN.

## Timing
- Reset values: state IDLE, `READY=1`, `BUSY=0`, `DONE=0`, `SUM=0`, `COUT=0`, `OVF=0`, counter 0, internal registers 0.
- Reset mid-run aborts immediately. Outputs take reset values asynchronously; no `DONE` follows.
- Latency: if `START` is accepted at edge t, RUN spans edges t+1 … t+N. Results update and `DONE` rises at edge t+N and stays high for exactly one cycle.
- Throughput: one result per N cycles with back-to-back `START` asserted in FIN.
- Counter width is `$clog2(N)`, minimum 1. When `N=1`, RUN lasts one edge.
- The first `START` after reset release is accepted on the first rising edge at which `RST_N=1`.

## Structure
- Shared package `alu_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2).
  - Add/subtract mode constants.
  - The parameter legality check macro.
- One sub-module, `adder_slice`:
  - Purely combinational `DIGIT`-bit ripple chain of full-adder cells.
  - Outputs: digit sum, carry-out, and the carry into its top bit (used for `OVF`).
- The top level holds the FSM, counter, operand shift registers, carry register and result registers.

## Test plan
All scenarios use `WIDTH=8, DIGIT=2` unless stated.
1. **Signed overflow:** `A=8'h7F, B=8'h01`, add, `CIN=0` → `DONE` exactly 4 cycles after accept; `SUM=8'h80, COUT=0, OVF=1`.
2. **Subtract with borrow:** `A=8'h05, B=8'h07`, `SUB=1` → `SUM=8'hFE, COUT=0, OVF=0`. Then `A=8'hFF, B=8'h01`, add → `SUM=8'h00, COUT=1, OVF=0`.
3. **Back-to-back and ignored start:**
   - Hold `START=1` in FIN with new operands → next `DONE` 4 cycles later, with no IDLE cycle in between.
   - `START` pulsed during RUN → ignored; result unchanged.
4. **Reset mid-run:** assert `RST_N=0` at RUN cycle 2 → all outputs zero immediately and no `DONE`. After release, `READY=1` and a fresh operation completes normally.
5. **Exhaustive reference sweep:** `WIDTH=4` with `DIGIT=1`, 2 and 4, all A, B, CIN and SUB combinations. Compare `{COUT, SUM}` and `OVF` against a behavioural model; latency must be 4, 2 and 1 respectively.
